// File: rtl/cab_slave_if.sv
// cab_slave_if -- bus bundle for the CAB register slave.
//
// Groups the CAB phase channel (request/accept, write phases, read data
// phases, error flag) and the register-access channel (request, address,
// write data, ack, read data).
//
// Modports:
//   slave  : the cab_slave side (receives CAB phases, issues register accesses)
//   master : the environment side (CAB master plus register file responder)

`timescale 1ns/1ps

interface cab_slave_if;
   // CAB phase channel
   logic        cab_xxi_sreq;
   logic [15:0] cab_xxi_swdata;
   logic        xxi_cab_sreq_rdy;
   logic        xxi_cab_sdn;
   logic [15:0] xxi_cab_srdata;
   logic        xxo_cab_serr;

   // Register access channel
   logic        xxo_reg_req;
   logic        xxo_reg_lan;
   logic [15:0] xxo_reg_addr;
   logic        xxo_reg_wr;
   logic [31:0] xxo_reg_wdata;
   logic        reg_xxo_ack;
   logic [31:0] reg_xxo_rdata;

   modport slave (
      input  cab_xxi_sreq,
      input  cab_xxi_swdata,
      output xxi_cab_sreq_rdy,
      output xxi_cab_sdn,
      output xxi_cab_srdata,
      output xxo_cab_serr,
      output xxo_reg_req,
      output xxo_reg_lan,
      output xxo_reg_addr,
      output xxo_reg_wr,
      output xxo_reg_wdata,
      input  reg_xxo_ack,
      input  reg_xxo_rdata
   );

   modport master (
      output cab_xxi_sreq,
      output cab_xxi_swdata,
      input  xxi_cab_sreq_rdy,
      input  xxi_cab_sdn,
      input  xxi_cab_srdata,
      input  xxo_cab_serr,
      input  xxo_reg_req,
      input  xxo_reg_lan,
      input  xxo_reg_addr,
      input  xxo_reg_wr,
      input  xxo_reg_wdata,
      output reg_xxo_ack,
      output reg_xxo_rdata
   );
endinterface

// File: rtl/cab_slave.sv
// cab_slave -- converts CAB phase transactions into 32-bit register accesses.
//
// A transaction starts with an address phase {addr[13:0], lan, wr}. Writes
// follow with two data phases (low half, then high half). The access is then
// presented on the register channel until acked; reads return their 32-bit
// result as two read data phases (low half first).
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cab_slave_if.slave (CAB phase channel + register access channel)
//
// Build option:
//   CAB_SLAVE_TIMEOUT_EN : when defined, a register access left unacked for
//   256 cycles is abandoned; the sticky xxo_cab_serr flag is raised and a
//   read returns 32'hDEAD_BEEF. When undefined the slave waits forever and
//   xxo_cab_serr is tied low.

`timescale 1ns/1ps

module cab_slave (
   input logic        clk,
   input logic        rst_n,
   cab_slave_if.slave bus
);

   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_WDAT0 = 6'b000010,
      S_WDAT1 = 6'b000100,
      S_REQ   = 6'b001000,
      S_RDAT0 = 6'b010000,
      S_RDAT1 = 6'b100000
   } state_t;

   state_t      state_q;
   state_t      state_n;

   logic        sreq_rdy;
   logic        accept;
   logic        sdn;
   logic [15:0] srdata;
   logic        timeout;
   logic        serr;

   logic [13:0] addr_q;
   logic        lan_q;
   logic        wr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        reg_req_q;

   assign accept = bus.cab_xxi_sreq & sreq_rdy;

`ifdef CAB_SLAVE_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;
   logic       serr_q;

   // The counter rests at zero outside S_REQ, so every S_REQ entry starts
   // from zero; the 256th unacked cycle (count 255) abandons the access.
   assign timeout = (state_q == S_REQ) && !bus.reg_xxo_ack && (tmo_cnt_q == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= 8'h00;
      end else if (state_q != S_REQ) begin
         tmo_cnt_q <= 8'h00;
      end else if (!bus.reg_xxo_ack) begin
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
   end

   // Error flag stays set until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         serr_q <= 1'b0;
      end else if (timeout) begin
         serr_q <= 1'b1;
      end
   end

   assign serr = serr_q;
`else
   assign timeout = 1'b0;
   assign serr    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic; any encoding other than the six one-hot codes
   // falls back to S_IDLE.
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_n = bus.cab_xxi_swdata[0] ? S_WDAT0 : S_REQ;
            end
         end
         S_WDAT0: begin
            if (accept) begin
               state_n = S_WDAT1;
            end
         end
         S_WDAT1: begin
            if (accept) begin
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.reg_xxo_ack || timeout) begin
               state_n = wr_q ? S_IDLE : S_RDAT0;
            end
         end
         S_RDAT0: state_n = S_RDAT1;
         S_RDAT1: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Output decode; read data is forced to zero outside the data phases.
   always_comb begin
      sreq_rdy = 1'b0;
      sdn      = 1'b0;
      srdata   = 16'h0000;
      case (state_q)
         S_IDLE, S_WDAT0, S_WDAT1: sreq_rdy = 1'b1;
         S_RDAT0: begin
            sdn    = 1'b1;
            srdata = rdata_q[15:0];
         end
         S_RDAT1: begin
            sdn    = 1'b1;
            srdata = rdata_q[31:16];
         end
         default: begin
            sreq_rdy = 1'b0;
         end
      endcase
   end

   // Transaction datapath. reg_req is its own flop, loaded from the
   // next state, so it is glitch-free and exactly covers S_REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= 14'h0000;
         lan_q     <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= 32'h0000_0000;
         rdata_q   <= 32'h0000_0000;
         reg_req_q <= 1'b0;
      end else begin
         reg_req_q <= (state_n == S_REQ);
         if ((state_q == S_IDLE) && accept) begin
            addr_q <= bus.cab_xxi_swdata[15:2];
            lan_q  <= bus.cab_xxi_swdata[1];
            wr_q   <= bus.cab_xxi_swdata[0];
         end
         if ((state_q == S_WDAT0) && accept) begin
            wdata_q[15:0] <= bus.cab_xxi_swdata;
         end
         if ((state_q == S_WDAT1) && accept) begin
            wdata_q[31:16] <= bus.cab_xxi_swdata;
         end
         if ((state_q == S_REQ) && !wr_q) begin
            if (bus.reg_xxo_ack) begin
               rdata_q <= bus.reg_xxo_rdata;
            end else if (timeout) begin
               rdata_q <= 32'hDEAD_BEEF;
            end
         end
      end
   end

   assign bus.xxi_cab_sreq_rdy = sreq_rdy;
   assign bus.xxi_cab_sdn      = sdn;
   assign bus.xxi_cab_srdata   = srdata;
   assign bus.xxo_cab_serr     = serr;
   assign bus.xxo_reg_req      = reg_req_q;
   assign bus.xxo_reg_lan      = lan_q;
   assign bus.xxo_reg_addr     = {addr_q, 2'b00};
   assign bus.xxo_reg_wr       = wr_q;
   assign bus.xxo_reg_wdata    = wdata_q;

endmodule

// File: tb/tb_cab_slave.sv
// tb_cab_slave -- scoreboard bench for cab_slave.
//
// A driver issues CAB transactions and pushes the expected register access
// and expected read data halves into queues. A responder plays the register
// file (its contents are built only from what the DUT writes). A monitor pops
// and compares whenever the DUT presents a register request or read data.
// The driver's own view of the register file decides what every read must
// return. Build option CAB_SLAVE_TIMEOUT_EN selects the matching timeout test.

`timescale 1ns/1ps

module tb_cab_slave;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cab_slave_if bus ();

   cab_slave dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] addr;
      logic        lan;
      logic        wr;
      logic [31:0] wdata;
   } req_t;

   req_t        exp_req_q [$];
   logic [15:0] exp_rd_q  [$];
   int          delay_q   [$];
   logic [31:0] drv_model [int];
   logic [31:0] rsp_store [int];

   int total = 0;
   int bad   = 0;

   function automatic int key_of(input logic lan, input logic [13:0] addr);
      return int'({lan, addr});
   endfunction

   function automatic logic [31:0] default_val(input int k);
      logic [31:0] kk;
      kk = k;
      return 32'h5A00_0000 ^ (kk * 32'h0001_0203);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", name, actual, expected);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      total++;
      bad++;
      $display("[TB] FAIL %s %s", name, what);
   endtask

   // Present one phase and hold it until it is accepted (rdy seen at a negedge
   // is the value the DUT samples at the following rising edge).
   task automatic send_phase(input logic [15:0] data);
      bit done = 1'b0;
      bus.cab_xxi_sreq   = 1'b1;
      bus.cab_xxi_swdata = data;
      for (int n = 0; n < 3000 && !done; n++) begin
         done = bus.xxi_cab_sreq_rdy;
         @(negedge clk);
      end
      if (!done) fail_now("phase_accept", "got=stalled exp=accepted");
   endtask

   task automatic applyStimulus(input logic wr, input logic lan, input logic [13:0] addr,
                                input logic [31:0] wdata, input int delay);
      req_t        r;
      int          k;
      logic [31:0] rv;
      r.addr  = addr;
      r.lan   = lan;
      r.wr    = wr;
      r.wdata = wdata;
      exp_req_q.push_back(r);
      delay_q.push_back(delay);
      k = key_of(lan, addr);
      if (wr) begin
         drv_model[k] = wdata;
      end else begin
         if (delay < 0) rv = 32'hDEAD_BEEF;
         else if (drv_model.exists(k)) rv = drv_model[k];
         else rv = default_val(k);
         exp_rd_q.push_back(rv[15:0]);
         exp_rd_q.push_back(rv[31:16]);
      end
      send_phase({addr, lan, wr});
      if (wr) begin
         send_phase(wdata[15:0]);
         send_phase(wdata[31:16]);
      end
      bus.cab_xxi_sreq   = 1'b0;
      bus.cab_xxi_swdata = 16'($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_sreq_rdy"}, bus.xxi_cab_sreq_rdy, 32'd1);
      checkOutput({tag, "_sdn"},      bus.xxi_cab_sdn,      32'd0);
      checkOutput({tag, "_srdata"},   bus.xxi_cab_srdata,   32'd0);
      checkOutput({tag, "_reg_req"},  bus.xxo_reg_req,      32'd0);
      checkOutput({tag, "_reg_addr"}, bus.xxo_reg_addr,     32'd0);
      checkOutput({tag, "_reg_lan"},  bus.xxo_reg_lan,      32'd0);
      checkOutput({tag, "_reg_wr"},   bus.xxo_reg_wr,       32'd0);
      checkOutput({tag, "_reg_wdata"},bus.xxo_reg_wdata,    32'd0);
      checkOutput({tag, "_serr"},     bus.xxo_cab_serr,     32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_req_q.size() != 0 || exp_rd_q.size() != 0 || bus.xxo_reg_req ||
              !bus.xxi_cab_sreq_rdy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("drain", "got=busy exp=idle");
      repeat (2) @(negedge clk);
   endtask

   // Register file responder: acks after the per-transaction delay (negative
   // means never), throws stray acks while no request is pending.
   initial begin : responder
      int cnt;
      int dly;
      int k;
      bit active;
      active = 1'b0;
      cnt    = 0;
      dly    = 0;
      bus.reg_xxo_ack   = 1'b0;
      bus.reg_xxo_rdata = 32'h0;
      forever begin
         @(negedge clk);
         bus.reg_xxo_ack   = 1'b0;
         bus.reg_xxo_rdata = $urandom;
         if (!rst_n) begin
            active = 1'b0;
            continue;
         end
         if (bus.xxo_reg_req) begin
            if (!active) begin
               active = 1'b1;
               cnt    = 0;
               dly    = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            end
            if (dly >= 0 && cnt == dly) begin
               k = key_of(bus.xxo_reg_lan, bus.xxo_reg_addr[15:2]);
               bus.reg_xxo_ack = 1'b1;
               if (bus.xxo_reg_wr) rsp_store[k] = bus.xxo_reg_wdata;
               else if (rsp_store.exists(k)) bus.reg_xxo_rdata = rsp_store[k];
               else bus.reg_xxo_rdata = default_val(k);
            end
            cnt++;
         end else begin
            active = 1'b0;
            bus.reg_xxo_ack = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Monitor: samples 2 ns after the falling edge so the responder's ack for
   // the coming rising edge is already visible.
   initial begin : monitor
      bit          prev_req;
      bit          ack_taken;
      req_t        cur;
      logic [15:0] eh;
      prev_req  = 1'b0;
      ack_taken = 1'b0;
      cur.addr  = '0;
      cur.lan   = 1'b0;
      cur.wr    = 1'b0;
      cur.wdata = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_req  = 1'b0;
            ack_taken = 1'b0;
            continue;
         end
         if (ack_taken) begin
            checkOutput("req_drop_after_ack", bus.xxo_reg_req, 32'd0);
            if (cur.wr) checkOutput("wr_ack_to_rdy", bus.xxi_cab_sreq_rdy, 32'd1);
            else        checkOutput("rd_ack_to_sdn", bus.xxi_cab_sdn, 32'd1);
         end
         if (bus.xxo_reg_req && !prev_req) begin
            if (exp_req_q.size() == 0) begin
               fail_now("unexpected_reg_req", "got=req exp=none");
            end else begin
               cur = exp_req_q.pop_front();
               checkOutput("reg_addr", bus.xxo_reg_addr, {16'h0, cur.addr, 2'b00});
               checkOutput("reg_lan",  bus.xxo_reg_lan,  {31'h0, cur.lan});
               checkOutput("reg_wr",   bus.xxo_reg_wr,   {31'h0, cur.wr});
               if (cur.wr) checkOutput("reg_wdata", bus.xxo_reg_wdata, cur.wdata);
            end
         end else if (bus.xxo_reg_req) begin
            checkOutput("req_stable_addr", {bus.xxo_reg_lan, bus.xxo_reg_wr, bus.xxo_reg_addr},
                        {14'h0, cur.lan, cur.wr, cur.addr, 2'b00});
            if (cur.wr) checkOutput("req_stable_wdata", bus.xxo_reg_wdata, cur.wdata);
         end
         if (bus.xxi_cab_sdn) begin
            if (exp_rd_q.size() == 0) begin
               fail_now("unexpected_sdn", "got=sdn exp=none");
            end else begin
               eh = exp_rd_q.pop_front();
               checkOutput("srdata", bus.xxi_cab_srdata, {16'h0, eh});
            end
         end else begin
            checkOutput("srdata_zero_when_idle", bus.xxi_cab_srdata, 32'd0);
         end
         ack_taken = bus.xxo_reg_req && bus.reg_xxo_ack;
         prev_req  = bus.xxo_reg_req;
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : main
      int n;
      bus.cab_xxi_sreq   = 1'b0;
      bus.cab_xxi_swdata = 16'h0000;
      $display("[TB] starting cab_slave scoreboard run");

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed write: 0x0049, 0x5678, 0x1234, ack two cycles into S_REQ.
      applyStimulus(1'b1, 1'b0, 14'h12, 32'h1234_5678, 2);
      drain();

      // Directed read with a known register value.
      drv_model[key_of(1'b1, 14'h14)] = 32'hCAFE_F00D;
      rsp_store[key_of(1'b1, 14'h14)] = 32'hCAFE_F00D;
      applyStimulus(1'b0, 1'b1, 14'h14, 32'h0, 1);
      drain();

      // Back-to-back write then read-back with sreq never dropping.
      applyStimulus(1'b1, 1'b1, 14'h21, 32'hA1B2_C3D4, 0);
      applyStimulus(1'b0, 1'b1, 14'h21, 32'h0, 0);
      drain();

      // Random traffic over a small address space so reads hit earlier writes.
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       14'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      checkOutput("serr_clear_before_stall", bus.xxo_cab_serr, 32'd0);

`ifdef CAB_SLAVE_TIMEOUT_EN
      // Read that is never acked: abandoned after 256 cycles with DEADBEEF.
      applyStimulus(1'b0, 1'b0, 14'h3, 32'h0, -1);
      n = 0;
      while (bus.xxo_reg_req && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_req_cycles", n, 32'd256);
      drain();
      checkOutput("serr_set_after_timeout", bus.xxo_cab_serr, 32'd1);
      applyStimulus(1'b1, 1'b0, 14'h4, 32'h0BAD_F00D, 1);
      drain();
      checkOutput("serr_sticky", bus.xxo_cab_serr, 32'd1);
`else
      // Without the timeout the request must still be pending at cycle 1000.
      applyStimulus(1'b0, 1'b0, 14'h3, 32'h0, 1005);
      n = 0;
      repeat (1000) @(negedge clk);
      checkOutput("no_timeout_req_held", bus.xxo_reg_req, 32'd1);
      checkOutput("serr_tied_low", bus.xxo_cab_serr, 32'd0);
      drain();
`endif

      // Reset while waiting for the second write data phase.
      send_phase({14'h5, 1'b0, 1'b1});
      send_phase(16'hAAAA);
      bus.cab_xxi_sreq = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_wdat1");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 14'h5, 32'h5555_AAAA, 1);
      applyStimulus(1'b0, 1'b0, 14'h5, 32'h0, 2);
      drain();

      // Reset during the first read data phase; no further sdn may appear.
      applyStimulus(1'b0, 1'b0, 14'h6, 32'h0, 0);
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         if (bus.xxi_cab_sdn) break;
         n++;
      end
      if (n >= 50) fail_now("wait_rdat0", "got=no_sdn exp=sdn");
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_rdat0");
      exp_rd_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      applyStimulus(1'b0, 1'b0, 14'h6, 32'h0, 1);
      drain();

      checkOutput("req_queue_empty", exp_req_q.size(), 32'd0);
      checkOutput("rd_queue_empty", exp_rd_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cab_slave.md
CAB_SLAVE -- requirements
Module: cab_slave

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cab_xxi_sreq  in  1  CAB phase request from master.
REQ-004 SHALL have: cab_xxi_swdata  in  16  phase data: address phase {addr[13:0], lan, wr}; data phases low half, then high half.
REQ-005 SHALL have: xxi_cab_sreq_rdy  out  1  phase accepted when sreq & sreq_rdy.
REQ-006 SHALL have: xxi_cab_sdn  out  1  read data phase valid.
REQ-007 SHALL have: xxi_cab_srdata  out  16  read data (low half first).
REQ-008 SHALL have: xxo_reg_req  out  1  register access request, held until ack.
REQ-009 SHALL have: xxo_reg_lan  out  1  LAN port (1: lan1, 0: lan0).
REQ-010 SHALL have: xxo_reg_addr  out  16  byte address {addr[13:0], 2'b00}.
REQ-011 SHALL have: xxo_reg_wr  out  1  1: write, 0: read.
REQ-012 SHALL have: xxo_reg_wdata  out  32  write data.
REQ-013 SHALL have: reg_xxo_ack  in  1  access done; rdata valid when ack=1.
REQ-014 SHALL have: reg_xxo_rdata  in  32  read data.
REQ-015 SHALL have: xxo_cab_serr  out  1  sticky timeout flag (see Configuration).

Function
REQ-016 SHALL implement one-hot FSM with states S_IDLE, S_WDAT0, S_WDAT1, S_REQ, S_RDAT0, S_RDAT1.
REQ-017 sreq_rdy SHALL be 1 in S_IDLE/S_WDAT0/S_WDAT1 and 0 otherwise.
REQ-018 S_IDLE on accept: SHALL latch addr/lan/wr; go to S_WDAT0 if wr=1, else S_REQ.
REQ-019 S_WDAT0 on accept: SHALL latch wdata[15:0], go S_WDAT1; S_WDAT1 on accept: latch wdata[31:16], go S_REQ.
REQ-020 xxo_reg_req SHALL be registered, 1 exactly while in S_REQ; address/lan/wr/wdata SHALL stay stable throughout.
REQ-021 S_REQ with ack=1: write -> S_IDLE; read -> capture rdata[31:0], go S_RDAT0.
REQ-022 ack in the first S_REQ cycle SHALL be legal; ack outside S_REQ SHALL be ignored.
REQ-023 S_RDAT0 SHALL drive sdn=1 with srdata=rdata[15:0] for one cycle, then S_RDAT1 with sdn=1 and srdata=rdata[31:16] for one cycle, then S_IDLE.
REQ-024 srdata SHALL be 16'h0 whenever sdn=0.
REQ-025 Latency: write ack to sreq_rdy=1 is 1 cycle. Read ack to first sdn is 1 cycle.
REQ-026 sreq held while sreq_rdy=0 SHALL NOT be consumed; back-to-back transactions SHALL be accepted from the first S_IDLE cycle.
REQ-027 Any illegal state encoding SHALL return to S_IDLE next cycle.

Reset
REQ-028 On rst_n=0: state S_IDLE, sreq_rdy=1, sdn=0, srdata=0, reg_req=0, reg_addr=0, reg_lan=0, reg_wr=0, reg_wdata=0, serr=0, timeout counter=0.
REQ-029 Reset mid-transaction SHALL abort it immediately with no further reg_req or sdn.

Configuration
REQ-030 Macro CAB_SLAVE_TIMEOUT_EN defined: 8-bit counter cleared on S_REQ entry, incremented each S_REQ cycle without ack; at 255 with no ack, SHALL deassert reg_req, set serr=1 (sticky until reset), complete write to S_IDLE, complete read returning 32'hDEAD_BEEF via S_RDAT0/S_RDAT1.
REQ-031 Macro undefined: S_REQ SHALL wait for ack indefinitely; serr SHALL be tied 0; counter absent.

Verification
REQ-032 Write: phases 16'h0049 (addr 0x12, lan 0, wr 1), 16'h5678, 16'h1234 with ack 2 cycles later -> reg_addr=16'h0048, reg_lan=0, reg_wr=1, reg_wdata=32'h12345678 with a single reg_req pulse train; sreq_rdy=1 next cycle after ack.
REQ-033 Read: phase 16'h0052 (addr 0x14, lan 1, wr 0), ack with rdata=32'hCAFE_F00D -> sdn for 2 cycles, srdata=16'hF00D then 16'hCAFE.
REQ-034 Back-to-back: write then read with sreq held high continuously -> no phase dropped or duplicated; both complete.
REQ-035 Timeout (macro on): read, never ack -> reg_req drops after 256 cycles in S_REQ, srdata=16'hBEEF then 16'hDEAD, serr=1; macro off: still waiting at cycle 1000.
REQ-036 rst_n asserted during S_WDAT1 and during S_RDAT0 -> all outputs at reset values in the same cycle; next transaction completes normally.
